// File: rtl/orv64_param_pkg.sv
// Purpose: shared ORV64 sizing parameters and small ID types.
// Latency: n/a (types only).
// Backpressure: n/a.
package orv64_param_pkg;

    localparam int N_REQ_MAX = 8;

    typedef logic [$clog2(N_REQ_MAX)-1:0] orv64_l2_arb_req_id_t;

endpackage

// File: rtl/orv64_typedef_pkg.sv
// Purpose: shared ORV64 L2 request/response payload types.
// Latency: n/a (types only).
// Backpressure: n/a.
package orv64_typedef_pkg;

    typedef enum logic [1:0] {
        REQ_READ  = 2'd0,
        REQ_WRITE = 2'd1,
        REQ_LR    = 2'd2,
        REQ_SC    = 2'd3
    } cpu_req_type_t;

    typedef struct packed {
        cpu_req_type_t req_type;
        logic [39:0]   addr;
        logic [63:0]   data;
        logic [7:0]    mask;
    } cpu_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } cpu_resp_t;

endpackage

// File: rtl/orv64_l2_arb_order_fifo.sv
// Purpose: register-based order FIFO holding requester IDs of in-flight L2 requests.
// Latency: head visible the cycle after push into an empty FIFO; pop frees the slot next cycle.
// Backpressure: push ignored when full, pop ignored when empty; owner gates with full/empty.
module orv64_l2_arb_order_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    cnt
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cnt   = CW'(wr_ptr - rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/orv64_l2_port_arb.sv
// Purpose: round-robin share of one L2 cpu_req/cpu_resp port with in-order response steering.
// Latency: 0-cycle request grant and 0-cycle response steering (both combinational).
// Backpressure: grant locks while L2 stalls; requests blocked at MAX_OUTST; head owner's resp_ready stalls L2.
module orv64_l2_port_arb
    import orv64_typedef_pkg::*;
    import orv64_param_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  cpu_req_t                       req [N_REQ],
    output logic [N_REQ-1:0]               resp_valid,
    input  logic [N_REQ-1:0]               resp_ready,
    output cpu_resp_t                      resp [N_REQ],
    output logic                           l2_req_valid,
    input  logic                           l2_req_ready,
    output cpu_req_t                       l2_req,
    input  logic                           l2_resp_valid,
    output logic                           l2_resp_ready,
    input  cpu_resp_t                      l2_resp,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           err_orphan_resp
);

    localparam int GW = $clog2(N_REQ);

    logic [GW-1:0]        last_gnt;
    logic [GW-1:0]        lock_id;
    logic                 lock_vld;
    logic [GW-1:0]        rr_gnt;
    logic [GW-1:0]        rr_cand;
    logic [GW-1:0]        gnt;
    logic [GW-1:0]        head_id;
    orv64_l2_arb_req_id_t fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Walk from the farthest candidate back to last_gnt+1 so the nearest valid one wins.
    always_comb begin
        rr_gnt  = last_gnt;
        rr_cand = last_gnt;
        for (int i = N_REQ; i >= 1; i--) begin
            rr_cand = GW'((int'(last_gnt) + i) % N_REQ);
            if (req_valid[rr_cand]) rr_gnt = rr_cand;
        end
    end

    assign gnt          = lock_vld ? lock_id : rr_gnt;
    assign l2_req_valid = (|req_valid) && !fifo_full && !rst;
    assign l2_req       = req[gnt];
    assign push         = l2_req_valid && l2_req_ready;
    assign req_ready    = push ? (N_REQ'(1) << gnt) : '0;

    assign head_id       = fifo_head[GW-1:0];
    assign resp_valid    = (l2_resp_valid && !fifo_empty) ? (N_REQ'(1) << head_id) : '0;
    assign l2_resp_ready = fifo_empty ? 1'b1 : resp_ready[head_id];
    assign pop           = l2_resp_valid && l2_resp_ready && !fifo_empty;

    for (genvar g = 0; g < N_REQ; g++) begin : g_resp
        assign resp[g] = l2_resp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt        <= GW'(N_REQ - 1);
            lock_vld        <= 1'b0;
            lock_id         <= '0;
            err_orphan_resp <= 1'b0;
        end else begin
            if (push) begin
                last_gnt <= gnt;
                lock_vld <= 1'b0;
            end else if (l2_req_valid) begin
                lock_vld <= 1'b1;
                lock_id  <= gnt;
            end
            if (l2_resp_valid && fifo_empty) err_orphan_resp <= 1'b1;
        end
    end

    orv64_l2_arb_order_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH ($bits(orv64_l2_arb_req_id_t))
    ) u_order_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (orv64_l2_arb_req_id_t'(gnt)),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head),
        .cnt      (outst_cnt)
    );

endmodule

// File: tb/tb_orv64_l2_port_arb.sv
// Purpose: bench for orv64_l2_port_arb, directed scenarios plus random traffic vs a queue model.
// Latency: inputs driven 1ns after posedge, outputs sampled 4ns after posedge.
// Backpressure: randomized l2_req_ready / resp_ready; locked requester held valid.
module tb_orv64_l2_port_arb;
    import orv64_typedef_pkg::*;

    localparam int N = 4;
    localparam int M = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    cpu_req_t        req [N];
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    cpu_resp_t       resp [N];
    logic            l2_req_valid;
    logic            l2_req_ready;
    cpu_req_t        l2_req;
    logic            l2_resp_valid;
    logic            l2_resp_ready;
    cpu_resp_t       l2_resp;
    logic [3:0]      outst_cnt;
    logic            err_orphan_resp;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: owners of in-flight requests in issue order, plus RR/lock/error state.
    int q[$];
    int gnt_log[$];
    int last_g;
    bit locked;
    int lock_g;
    bit err_m;

    always #5 clk = ~clk;

    orv64_l2_port_arb #(.N_REQ(N), .MAX_OUTST(M)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req             (req),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp            (resp),
        .l2_req_valid    (l2_req_valid),
        .l2_req_ready    (l2_req_ready),
        .l2_req          (l2_req),
        .l2_resp_valid   (l2_resp_valid),
        .l2_resp_ready   (l2_resp_ready),
        .l2_resp         (l2_resp),
        .outst_cnt       (outst_cnt),
        .err_orphan_resp (err_orphan_resp)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic cpu_req_t rand_req();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[$bits(cpu_req_t)-1:0];
    endfunction

    function automatic cpu_resp_t rand_resp();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[$bits(cpu_resp_t)-1:0];
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] rv);
        for (int k = 1; k <= N; k++) begin
            if (rv[(last + k) % N]) return (last + k) % N;
        end
        return last;
    endfunction

    task automatic model_reset();
        q.delete();
        gnt_log.delete();
        last_g = N - 1;
        locked = 1'b0;
        lock_g = 0;
        err_m  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_l2_req_valid"}, l2_req_valid, 0);
        check_val({tag, "_req_ready"}, req_ready, 0);
        check_val({tag, "_resp_valid"}, resp_valid, 0);
        check_val({tag, "_l2_resp_ready"}, l2_resp_ready, 1);
        check_val({tag, "_outst_cnt"}, outst_cnt, 0);
        check_val({tag, "_err"}, err_orphan_resp, 0);
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        req_valid     = '0;
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b0;
        resp_ready    = '1;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: compare all outputs against the model, then advance the model.
    task automatic step();
        bit       ev;
        int       eg;
        int       head;
        bit       erdy;
        logic [N-1:0] erv;
        #3;
        ev = (req_valid != '0) && (q.size() < M);
        eg = locked ? lock_g : rr_pick(last_g, req_valid);
        check_val("l2_req_valid", l2_req_valid, ev);
        check_val("req_ready", req_ready, (ev && l2_req_ready) ? (1 << eg) : 0);
        if (ev) check_val("l2_req", l2_req, req[eg]);
        check_val("outst_cnt", outst_cnt, q.size());
        erv  = '0;
        erdy = 1'b1;
        head = -1;
        if (q.size() > 0) begin
            head = q[0];
            erdy = resp_ready[head];
            if (l2_resp_valid) erv[head] = 1'b1;
        end
        check_val("resp_valid", resp_valid, erv);
        check_val("l2_resp_ready", l2_resp_ready, erdy);
        if (head >= 0 && l2_resp_valid) check_val("resp_dat", resp[head], l2_resp);
        check_val("err_orphan_resp", err_orphan_resp, err_m);

        if (l2_resp_valid) begin
            if (q.size() == 0) err_m = 1'b1;
            else if (erdy) void'(q.pop_front());
        end
        if (ev && l2_req_ready) begin
            q.push_back(eg);
            gnt_log.push_back(eg);
            last_g = eg;
            locked = 1'b0;
        end else if (ev) begin
            locked = 1'b1;
            lock_g = eg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid     = '0;
        l2_resp_valid = 1'b1;
        resp_ready    = '1;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            l2_resp = rand_resp();
            step();
        end
        l2_resp_valid = 1'b0;
        check_val("drain_cnt", outst_cnt, 0);
    endtask

    initial begin
        int exp_order [6];
        rst     = 1'b1;
        l2_resp = rand_resp();
        for (int i = 0; i < N; i++) req[i] = rand_req();
        apply_reset();

        // Single requester: three back-to-back grants to req 2.
        req_valid    = 4'b0100;
        l2_req_ready = 1'b1;
        repeat (3) step();
        req_valid = '0;
        check_val("single_cnt", outst_cnt, 3);
        check_val("single_ngnt", gnt_log.size(), 3);
        for (int i = 0; i < gnt_log.size(); i++) check_val("single_gnt", gnt_log[i], 2);
        drain();

        // Contention among 0, 1, 3.
        apply_reset();
        req_valid    = 4'b1011;
        l2_req_ready = 1'b1;
        repeat (6) step();
        req_valid = '0;
        exp_order = '{0, 1, 3, 0, 1, 3};
        check_val("rr_ngnt", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) check_val("rr_order", gnt_log[i], exp_order[i]);
        drain();

        // Lock: req 1 stalled 5 cycles while req 0 arrives.
        apply_reset();
        for (int i = 0; i < N; i++) req[i] = rand_req();
        req_valid    = 4'b0010;
        l2_req_ready = 1'b0;
        step();
        req_valid = 4'b0011;
        repeat (4) step();
        check_val("lock_payload", l2_req, req[1]);
        l2_req_ready = 1'b1;
        step();
        step();
        req_valid = '0;
        check_val("lock_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            check_val("lock_first", gnt_log[0], 1);
            check_val("lock_second", gnt_log[1], 0);
        end
        drain();

        // Full FIFO, then a pop and blocked push in the same cycle.
        apply_reset();
        req_valid    = 4'b0001;
        l2_req_ready = 1'b1;
        repeat (9) step();
        check_val("full_cnt", outst_cnt, M);
        check_val("full_rdy", req_ready, 0);
        l2_resp_valid = 1'b1;
        l2_resp       = rand_resp();
        step();
        l2_resp_valid = 1'b0;
        check_val("full_pop_cnt", outst_cnt, M - 1);
        step();
        check_val("full_refill_cnt", outst_cnt, M);
        req_valid = '0;

        // Response backpressure on head owner 0.
        l2_resp_valid = 1'b1;
        resp_ready    = 4'b1110;
        repeat (4) step();
        check_val("rbp_cnt", outst_cnt, M);
        drain();

        // Random traffic.
        apply_reset();
        repeat (400) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                if (!(locked && i == lock_g) && $urandom_range(0, 3) == 0) req[i] = rand_req();
            if (locked) req_valid[lock_g] = 1'b1;
            l2_req_ready  = ($urandom_range(0, 3) != 0);
            l2_resp_valid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            resp_ready    = 4'($urandom_range(0, 15));
            l2_resp       = rand_resp();
            step();
        end
        l2_resp_valid = 1'b0;
        l2_req_ready  = 1'b1;
        for (int k = 0; k < 4 && locked; k++) begin
            req_valid = '0;
            req_valid[lock_g] = 1'b1;
            step();
        end
        drain();

        // Orphan response.
        apply_reset();
        l2_resp_valid = 1'b1;
        l2_resp       = rand_resp();
        step();
        l2_resp_valid = 1'b0;
        step();
        check_val("orphan_flag", err_orphan_resp, 1);

        // Reset with three requests outstanding, inputs still active.
        req_valid    = 4'b0111;
        l2_req_ready = 1'b1;
        repeat (3) step();
        check_val("pre_rst_cnt", outst_cnt, 3);
        l2_resp_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        req_valid     = '0;
        l2_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
